// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: two valid/ready writeback channels plus the registered register-file write port.
// The pending scoreboard output exists only when WB_PENDING_EN is defined.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ch0_valid;
    logic [ADDR_W-1:0] ch0_rd;
    logic [DATA_W-1:0] ch0_data;
    logic              ch0_ready;
    logic              ch1_valid;
    logic [ADDR_W-1:0] ch1_rd;
    logic [DATA_W-1:0] ch1_data;
    logic              ch1_ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] Rd;
    logic [DATA_W-1:0] write_data;
    logic              idle;
`ifdef WB_PENDING_EN
    logic [31:0]       pending;
`endif

    modport slave (
        input  ch0_valid, ch0_rd, ch0_data,
        input  ch1_valid, ch1_rd, ch1_data,
        output ch0_ready, ch1_ready,
        output RegWrite, Rd, write_data, idle
`ifdef WB_PENDING_EN
        , output pending
`endif
    );

    modport master (
        output ch0_valid, ch0_rd, ch0_data,
        output ch1_valid, ch1_rd, ch1_data,
        input  ch0_ready, ch1_ready,
        input  RegWrite, Rd, write_data, idle
`ifdef WB_PENDING_EN
        , input pending
`endif
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU (ch0) and LSU (ch1) writeback channels.
// Optional WB_PENDING_EN adds a per-register pending bitmap for issue-stage stall decode.
module wb_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int RR_INIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);
    logic              full0_q, full0_d, full1_q, full1_d;
    logic [ADDR_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              age_q, age_d;
    logic              rr_q, rr_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant0, grant1;
    logic              accept0, accept1;

    // age_q=1 means ch1 holds the older entry; rr_q names the channel with priority.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        rr_d   = rr_q;
        if (full0_q && full1_q) begin
            if (rd0_q == rd1_q) begin
                grant0 = !age_q;
                grant1 = age_q;
            end else begin
                grant0 = !rr_q;
                grant1 = rr_q;
                rr_d   = !rr_q;
            end
        end else begin
            grant0 = full0_q;
            grant1 = full1_q;
        end
    end

    assign bus.ch0_ready = !full0_q || grant0;
    assign bus.ch1_ready = !full1_q || grant1;
    assign accept0       = bus.ch0_valid && bus.ch0_ready;
    assign accept1       = bus.ch1_valid && bus.ch1_ready;

    always_comb begin
        full0_d = accept0 || (full0_q && !grant0);
        rd0_d   = accept0 ? bus.ch0_rd   : rd0_q;
        data0_d = accept0 ? bus.ch0_data : data0_q;
        full1_d = accept1 || (full1_q && !grant1);
        rd1_d   = accept1 ? bus.ch1_rd   : rd1_q;
        data1_d = accept1 ? bus.ch1_data : data1_q;
        // The entry that was not just loaded is the older one; a tie favours ch0.
        age_d = age_q;
        if (accept0 && !accept1) begin
            age_d = 1'b1;
        end else if (accept1) begin
            age_d = 1'b0;
        end
    end

    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        if (grant0) begin
            regwrite_d = (rd0_q != '0);
            rd_d       = rd0_q;
            wdata_d    = data0_q;
        end else if (grant1) begin
            regwrite_d = (rd1_q != '0);
            rd_d       = rd1_q;
            wdata_d    = data1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full0_q    <= 1'b0;
            rd0_q      <= '0;
            data0_q    <= '0;
            full1_q    <= 1'b0;
            rd1_q      <= '0;
            data1_q    <= '0;
            age_q      <= 1'b0;
            rr_q       <= 1'(RR_INIT);
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            full0_q    <= full0_d;
            rd0_q      <= rd0_d;
            data0_q    <= data0_d;
            full1_q    <= full1_d;
            rd1_q      <= rd1_d;
            data1_q    <= data1_d;
            age_q      <= age_d;
            rr_q       <= rr_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.RegWrite   = regwrite_q;
    assign bus.Rd         = rd_q;
    assign bus.write_data = wdata_q;
    assign bus.idle       = !full0_q && !full1_q && !regwrite_q;

`ifdef WB_PENDING_EN
    logic [31:0] pending_c;

    // Register x0 never blocks issue, so bit 0 stays clear.
    always_comb begin
        pending_c = '0;
        for (int r = 1; r < 32; r++) begin
            pending_c[r] = (full0_q && (rd0_q == ADDR_W'(r)))
                        || (full1_q && (rd1_q == ADDR_W'(r)))
                        || (regwrite_q && (rd_q == ADDR_W'(r)));
        end
    end

    assign bus.pending = pending_c;
`endif
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (RegWrite/Rd/write_data) between two writeback sources: ch0 = ALU, ch1 = load/store unit.
- Each channel has a valid/ready handshake and a one-entry holding buffer.
- A round-robin arbiter, with an age override for same-destination conflicts, drains one buffered write per cycle.
- The write port outputs are registered and drive the register file directly.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- RR_INIT, 0, channel holding round-robin priority after reset (0 or 1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge
- ch0_valid  in  1  ALU writeback request
- ch0_rd  in  ADDR_W  ALU destination register
- ch0_data  in  DATA_W  ALU result
- ch0_ready  out  1  ALU buffer can accept this cycle
- ch1_valid  in  1  LSU writeback request
- ch1_rd  in  ADDR_W  LSU destination register
- ch1_data  in  DATA_W  load data
- ch1_ready  out  1  LSU buffer can accept this cycle
- RegWrite  out  1  register-file write enable (registered)
- Rd  out  ADDR_W  register-file write index (registered)
- write_data  out  DATA_W  register-file write data (registered)
- idle  out  1  both buffers empty and RegWrite low

Behaviour:
- Reset (reset==0 at a clk edge): both buffers invalid; age bit cleared; RR pointer = RR_INIT; RegWrite=0, Rd=0, write_data=0; idle=1. Any request in flight or buffered is discarded, with no write issued. chN_ready reads 1 in the first cycle after reset deasserts.
- Buffer state per channel: full flag, rd, data.
- chN_ready = !fullN || grantN, where grantN is this cycle's grant. It depends only on registered state, never on chN_valid.
- Accept: a transfer occurs when chN_valid && chN_ready at a clk edge. The buffer loads rd/data and full is set. Accept and grant on the same channel in the same cycle replace the buffer contents with the new entry (back-to-back, one write per cycle sustained).
- Arbitration (combinational from buffer state, one grant per cycle):
  - Only one buffer full: grant it.
  - Both full, rd differ: grant the RR-pointer channel. The pointer then moves to the other channel.
  - Both full, same rd: grant the older entry (age bit), and the pointer is not updated. This guarantees write ordering to the same register.
- Age bit tracks which buffer was filled first. Simultaneous fill of both empty buffers: ch0 is older.
- Write port: the granted entry is registered into Rd/write_data at the edge, so a buffered entry reaches the port 1 cycle after it is granted. Latency is 2 cycles from the accept edge to RegWrite high (accept edge, grant edge, RegWrite visible after the grant edge).
  - RegWrite = 1 for exactly one cycle per granted entry with rd != 0.
  - Granted entries with rd == 0 consume the slot: RegWrite=0 that cycle, Rd/write_data still updated.
  - No grant: RegWrite=0; Rd/write_data hold their previous values.
- No backpressure from the register file: the port accepts a write every cycle.
- Sustained throughput: one write per cycle total. With both channels streaming distinct rd, grants alternate ch0, ch1, ch0, … from RR_INIT.
- idle = !full0 && !full1 && !RegWrite.

Optional Feature:
- Macro: WB_PENDING_EN.
- Defined: adds output pending [31:0]. Bit r is set if either full buffer holds rd==r (r != 0), or RegWrite && Rd==r this cycle. Bit 0 is always 0. Decode uses the issue stage's stall logic. Reset value is 0.
- Undefined: the port is absent and no decode logic is generated; all other behaviour is identical.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with ch0_valid=1 -> RegWrite=0, Rd=0, write_data=0, idle=1; ch0_ready=1 in the first cycle after release.
- Single write latency: ch0 sends rd=5, data=0xDEADBEEF at edge T -> RegWrite=1, Rd=5, write_data=0xDEADBEEF after edge T+1 only; idle returns to 1 the following cycle.
- Round-robin: both channels stream distinct rd (ch0 rd=1,2,3; ch1 rd=10,11,12), RR_INIT=0 -> port sequence 1,10,2,11,3,12 with no gaps; ready never drops to 0 for either channel for more than 1 cycle.
- Same-rd ordering: ch1 sends rd=7, data=0x1 one cycle before ch0 sends rd=7, data=0x2 -> writes emitted as 0x1 then 0x2, with final register value 0x2; repeat with simultaneous fill -> ch0's data is written first.
- x0 drop: ch0 sends rd=0, data=0x55 -> RegWrite stays 0, Rd=0, write_data=0x55, and the grant slot is consumed.
- Mid-operation reset: both buffers full (rd=3, rd=4) and reset=0 asserted before the grant edge -> no RegWrite for rd 3 or 4; with WB_PENDING_EN, pending=0 after reset.
